// File: rtl/port_mailbox.sv
// port_mailbox
//
// Bidirectional word mailbox between the soc parallel I/O pins and a host
// ready/valid interface. Each direction has its own DEPTH-entry FIFO.
//
//   core -> host : the core flips CORE_OUT0[11] to offer CORE_OUT0[10:0].
//                  The word is pushed into the RX FIFO and ack0
//                  (CORE_IN0[11]) flips to match. The host drains the FIFO
//                  through RX_VALID/RX_DATA/RX_READY (first-word-fall-through).
//   host -> core : the host pushes through TX_VALID/TX_DATA/TX_READY. A
//                  two-state presenter places the FIFO head on CORE_IN1[10:0],
//                  flips req1 (CORE_IN1[11]) and pops the head once the core
//                  echoes the toggle on CORE_OUT1[11].
//
// Host handshake: a word moves on a rising CLK edge exactly when valid and
// ready are both high at that edge. A producer holds valid and data stable
// until that edge. Ready never depends combinationally on valid.
//
// Ports
//   CLK, RES            clock, synchronous active-high reset
//   CORE_OUT0 [11:0]    in : [11] request toggle, [10:0] payload
//   CORE_OUT1 [11:0]    in : [11] acknowledge toggle for host->core words
//   CORE_IN0  [11:0]    out: [11] ack0, [10:0] status word or zero
//   CORE_IN1  [11:0]    out: [11] req1, [10:0] presented payload
//   RX_VALID/RX_DATA/RX_READY   host side of the core->host FIFO
//   TX_VALID/TX_DATA/TX_READY   host side of the host->core FIFO
//
// Build option: PORT_MAILBOX_STATUS_EN turns CORE_IN0[10:0] into a
// registered status word (rx count, tx count, presenter waiting).

module port_mailbox #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        CLK,
    input  logic        RES,
    input  logic [11:0] CORE_OUT0,
    input  logic [11:0] CORE_OUT1,
    output logic [11:0] CORE_IN0,
    output logic [11:0] CORE_IN1,
    output logic        RX_VALID,
    output logic [10:0] RX_DATA,
    input  logic        RX_READY,
    input  logic        TX_VALID,
    input  logic [10:0] TX_DATA,
    output logic        TX_READY
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {PRES_IDLE = 1'b0, PRES_WAIT = 1'b1} pres_state_e;

    // ---------------- core -> host FIFO ----------------
    logic [10:0]   rx_mem_q [DEPTH];
    logic [AW-1:0] rx_wr_q, rx_rd_q;
    logic [AW:0]   rx_cnt_q, rx_cnt_d;
    logic          ack0_q;
    logic          rx_push, rx_pop;

    // Full is judged on the pre-edge count, so a pop in the same cycle
    // does not make room for a push until the next edge.
    assign rx_push  = (CORE_OUT0[11] != ack0_q) && (rx_cnt_q != FULL_CNT);
    assign rx_pop   = RX_VALID && RX_READY;
    assign RX_VALID = (rx_cnt_q != '0);
    assign RX_DATA  = rx_mem_q[rx_rd_q];

    always_comb begin
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + 1'b1;
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            rx_wr_q  <= '0;
            rx_rd_q  <= '0;
            rx_cnt_q <= '0;
            ack0_q   <= 1'b0;
        end else begin
            rx_cnt_q <= rx_cnt_d;
            if (rx_push) begin
                rx_wr_q <= rx_wr_q + 1'b1;
                ack0_q  <= ~ack0_q;
            end
            if (rx_pop) rx_rd_q <= rx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_push) rx_mem_q[rx_wr_q] <= CORE_OUT0[10:0];
    end

    // ---------------- host -> core FIFO ----------------
    logic [10:0]   tx_mem_q [DEPTH];
    logic [AW-1:0] tx_wr_q, tx_rd_q;
    logic [AW:0]   tx_cnt_q, tx_cnt_d;
    logic          tx_ready_q;
    logic          tx_push, tx_pop;

    assign tx_push  = TX_VALID && tx_ready_q;
    assign TX_READY = tx_ready_q;

    always_comb begin
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + 1'b1;
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            tx_wr_q    <= '0;
            tx_rd_q    <= '0;
            tx_cnt_q   <= '0;
            tx_ready_q <= 1'b0;
        end else begin
            tx_cnt_q   <= tx_cnt_d;
            // Registered so TX_READY stays low through reset and reflects
            // "not full" from the first edge after release.
            tx_ready_q <= (tx_cnt_d != FULL_CNT);
            if (tx_push) tx_wr_q <= tx_wr_q + 1'b1;
            if (tx_pop)  tx_rd_q <= tx_rd_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (tx_push) tx_mem_q[tx_wr_q] <= TX_DATA;
    end

    // ---------------- presenter FSM ----------------
    pres_state_e pres_state_q, pres_state_d;
    logic        req1_q, req1_d;
    logic [10:0] in1_pay_q, in1_pay_d;

    always_comb begin
        pres_state_d = pres_state_q;
        req1_d       = req1_q;
        in1_pay_d    = in1_pay_q;
        tx_pop       = 1'b0;
        case (pres_state_q)
            PRES_IDLE: begin
                // The head is only copied here; it leaves the FIFO when the
                // core acknowledges it.
                if (tx_cnt_q != '0) begin
                    in1_pay_d    = tx_mem_q[tx_rd_q];
                    req1_d       = ~req1_q;
                    pres_state_d = PRES_WAIT;
                end
            end
            PRES_WAIT: begin
                if (CORE_OUT1[11] == req1_q) begin
                    tx_pop       = 1'b1;
                    pres_state_d = PRES_IDLE;
                end
            end
            default: pres_state_d = PRES_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            pres_state_q <= PRES_IDLE;
            req1_q       <= 1'b0;
            in1_pay_q    <= '0;
        end else begin
            pres_state_q <= pres_state_d;
            req1_q       <= req1_d;
            in1_pay_q    <= in1_pay_d;
        end
    end

    assign CORE_IN1 = {req1_q, in1_pay_q};

    // ---------------- core-side status ----------------
`ifdef PORT_MAILBOX_STATUS_EN
    logic [10:0] status_q;
    logic [4:0]  rx_cnt_w, tx_cnt_w;
    logic [3:0]  rx_cnt_sat, tx_cnt_sat;

    assign rx_cnt_w   = 5'(rx_cnt_q);
    assign tx_cnt_w   = 5'(tx_cnt_q);
    assign rx_cnt_sat = (rx_cnt_w > 5'd15) ? 4'hF : rx_cnt_w[3:0];
    assign tx_cnt_sat = (tx_cnt_w > 5'd15) ? 4'hF : tx_cnt_w[3:0];

    always_ff @(posedge CLK) begin
        if (RES) status_q <= '0;
        else     status_q <= {2'b00, (pres_state_q == PRES_WAIT), tx_cnt_sat, rx_cnt_sat};
    end

    assign CORE_IN0 = {ack0_q, status_q};
`else
    assign CORE_IN0 = {ack0_q, 11'd0};
`endif

endmodule

// File: tb/tb_port_mailbox.sv
module tb_port_mailbox;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        res;
    logic [11:0] core_out0, core_out1;
    logic [11:0] core_in0, core_in1;
    logic        rx_valid, rx_ready, tx_valid, tx_ready;
    logic [10:0] rx_data, tx_data;

    port_mailbox #(.DEPTH(DEPTH), .AW(AW)) dut (
        .CLK(clk), .RES(res),
        .CORE_OUT0(core_out0), .CORE_OUT1(core_out1),
        .CORE_IN0(core_in0), .CORE_IN1(core_in1),
        .RX_VALID(rx_valid), .RX_DATA(rx_data), .RX_READY(rx_ready),
        .TX_VALID(tx_valid), .TX_DATA(tx_data), .TX_READY(tx_ready)
    );

    // ---------------- scoreboard / reference model ----------------
    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] rx_q[$];     // words the host should see, in order
    logic [10:0] tx_q[$];     // words the core should see, in order
    logic        m_ack0, m_req1, m_wait, m_txrdy;
    logic [10:0] m_in1, m_status;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] sat15(input int n);
        return (n > 15) ? 4'hF : 4'(n);
    endfunction

    // Advance the reference by one clock edge using the inputs now applied.
    task automatic model_step();
        bit rx_push, rx_pop, tx_push;
        if (res) begin
            rx_q.delete(); tx_q.delete();
            m_ack0 = 0; m_req1 = 0; m_wait = 0; m_txrdy = 0;
            m_in1 = '0; m_status = '0;
        end else begin
            m_status = {2'b00, m_wait, sat15(tx_q.size()), sat15(rx_q.size())};
            rx_push = (core_out0[11] != m_ack0) && (rx_q.size() < DEPTH);
            rx_pop  = (rx_q.size() > 0) && rx_ready;
            tx_push = tx_valid && m_txrdy;
            if (rx_pop) void'(rx_q.pop_front());
            if (rx_push) begin
                rx_q.push_back(core_out0[10:0]);
                m_ack0 = ~m_ack0;
            end
            if (!m_wait && tx_q.size() > 0) begin
                m_in1  = tx_q[0];
                m_req1 = ~m_req1;
                m_wait = 1;
            end else if (m_wait && core_out1[11] == m_req1) begin
                void'(tx_q.pop_front());
                m_wait = 0;
            end
            if (tx_push) tx_q.push_back(tx_data);
            m_txrdy = (tx_q.size() < DEPTH);
        end
    endtask

    task automatic compare_all();
        logic [10:0] st;
`ifdef PORT_MAILBOX_STATUS_EN
        st = m_status;
`else
        st = '0;
`endif
        check("core_in0", core_in0, {m_ack0, st});
        check("core_in1", core_in1, {m_req1, m_in1});
        check("rx_valid", rx_valid, rx_q.size() > 0);
        if (rx_q.size() > 0) check("rx_data", rx_data, rx_q[0]);
        check("tx_ready", tx_ready, m_txrdy);
    endtask

    // ---------------- driver tasks ----------------
    // Inputs are changed at the falling edge; outputs are checked there too.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic core_send(input logic [10:0] w);
        core_out0 = {~m_ack0, w};
    endtask

    task automatic apply_reset(input int n);
        res = 1; core_out0 = '0; core_out1 = '0;
        rx_ready = 0; tx_valid = 0; tx_data = '0;
        repeat (n) tick();
        res = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        res = 1; core_out0 = '0; core_out1 = '0;
        rx_ready = 0; tx_valid = 0; tx_data = '0;
        m_ack0 = 0; m_req1 = 0; m_wait = 0; m_txrdy = 0; m_in1 = '0; m_status = '0;

        // Reset held for 12 cycles
        apply_reset(12);
        check("reset_in0", core_in0, 12'h000);
        check("reset_in1", core_in1, 12'h000);
        check("reset_txrdy", tx_ready, 0);
        tick();
        check("txrdy_after_release", tx_ready, 1);

        // Core->host single word
        core_out0 = 12'h855;
        tick();
        check("single_ack", core_in0[11], 1);
        check("single_valid", rx_valid, 1);
        check("single_data", rx_data, 11'h055);
        rx_ready = 1;
        tick();
        check("single_drained", rx_valid, 0);
        rx_ready = 0;

        // Backpressure: fill 8, 9th blocked until a pop
        for (int i = 1; i <= 8; i++) begin
            core_send(11'(i));
            tick();
        end
        core_send(11'd9);
        tick();
        check("full_no_ack_a", core_in0[11], !core_out0[11]);
        tick();
        check("full_no_ack_b", core_in0[11], !core_out0[11]);
        rx_ready = 1;
        tick();
        check("pop_edge_no_ack", core_in0[11], !core_out0[11]);
        rx_ready = 0;
        tick();
        check("ack_after_pop", core_in0[11], core_out0[11]);
        rx_ready = 1;
        for (int i = 2; i <= 9; i++) begin
            check("drain_order", rx_data, 32'(i));
            tick();
        end
        check("drained_empty", rx_valid, 0);
        rx_ready = 0;

        // Host->core: two words back to back
        tx_valid = 1; tx_data = 11'h123;
        tick();
        tx_data = 11'h456;
        tick();
        tx_valid = 0;
        check("present_first", core_in1, 12'h923);
        core_out1 = 12'h800;
        tick();
        tick();
        check("present_second", core_in1, 12'h456);
        core_out1 = 12'h000;
        tick();
        tick();
        check("present_idle_hold", core_in1, 12'h456);
        check("tx_empty_ready", tx_ready, 1);

        // Randomized traffic, rx/tx pressure varied by segment
        for (int seg = 0; seg < 6; seg++) begin
            int rdy_pct, vld_pct, echo_pct;
            rdy_pct  = $urandom_range(5, 95);
            vld_pct  = $urandom_range(5, 95);
            echo_pct = $urandom_range(5, 95);
            for (int c = 0; c < 400; c++) begin
                res = ($urandom_range(0, 299) == 0);
                if (res) begin
                    core_out0 = '0; core_out1 = '0;
                end else begin
                    if (core_out0[11] == m_ack0 && $urandom_range(0, 99) < 50)
                        core_send(11'($urandom));
                    if (core_out1[11] != m_req1 && $urandom_range(0, 99) < echo_pct)
                        core_out1 = {m_req1, 11'($urandom)};
                end
                rx_ready = ($urandom_range(0, 99) < rdy_pct);
                tx_valid = ($urandom_range(0, 99) < vld_pct);
                tx_data  = 11'($urandom);
                tick();
            end
        end
        res = 0;

        // Reset mid-transfer: 3 words each way, presenter waiting
        apply_reset(2);
        tick();
        for (int i = 0; i < 3; i++) begin
            core_send(11'h100 + 11'(i));
            tx_valid = 1; tx_data = 11'h200 + 11'(i);
            tick();
        end
        tx_valid = 0;
        tick();
        check("mid_in1_waiting", core_in1, 12'hA00);
        check("mid_rx_valid", rx_valid, 1);
        apply_reset(1);
        check("mid_rst_in1", core_in1, 12'h000);
        check("mid_rst_rxv", rx_valid, 0);
        check("mid_rst_in0", core_in0, 12'h000);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("no_stale_rx", rx_valid, 0);
            check("no_stale_in1", core_in1, 12'h000);
        end

        // Status word: 3 core words pending, 2 host words with presenter waiting
        for (int i = 0; i < 3; i++) begin
            core_send(11'h300 + 11'(i));
            tx_valid = (i < 2); tx_data = 11'h040 + 11'(i);
            tick();
        end
        tx_valid = 0;
        tick();
        tick();
`ifdef PORT_MAILBOX_STATUS_EN
        check("status_word", core_in0[10:0], 11'h123);
`else
        check("status_word", core_in0[10:0], 11'h000);
`endif
        check("status_in1", core_in1, 12'h840);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/port_mailbox.md
Name: port_mailbox

Overview:
- Bidirectional word mailbox attached to the soc parallel I/O pins.
- Core→host channel: consumes words the core drives on OUT0 and acknowledges them on IN0.
- Host→core channel: presents host words on IN1 and receives the core's acknowledge on OUT1.
- Toggle (two-phase) handshake on the core side; ready/valid with a FIFO per direction on the host side.

Parameters:
- DEPTH, 8, entries per FIFO; power of two, 2..16.
- AW, 3, log2(DEPTH); must match DEPTH.

Ports:
- CLK  in  1  system clock, shared with soc
- RES  in  1  synchronous reset, active-high
- CORE_OUT0  in  12  from soc OUT0: [11] request toggle, [10:0] payload
- CORE_OUT1  in  12  from soc OUT1: [11] acknowledge toggle for the host→core channel; [10:0] ignored
- CORE_IN0  out  12  to soc IN0: [11] acknowledge toggle for the core→host channel; [10:0] status/zero
- CORE_IN1  out  12  to soc IN1: [11] request toggle, [10:0] payload
- RX_VALID  out  1  core→host FIFO non-empty
- RX_DATA  out  11  core→host FIFO head, first-word-fall-through
- RX_READY  in  1  host pops the head when RX_VALID&&RX_READY
- TX_VALID  in  1  host offers a word
- TX_DATA  in  11  host word
- TX_READY  out  1  host→core FIFO not full

Behaviour:
- Reset (RES=1 at a rising edge) sets:
  - both FIFOs empty; ack0=0, req1=0
  - CORE_IN0=0, CORE_IN1=0
  - RX_VALID=0; TX_READY=0 while RES is high, 1 from the first non-reset cycle
- Reset mid-operation discards all queued words. Toggles return to 0, which matches the core's reset state because RES is shared.
- Core→host channel:
  - A request is pending when CORE_OUT0[11] != ack0.
  - If a request is pending and the FIFO count < DEPTH at the edge: push CORE_OUT0[10:0] and flip ack0. The new CORE_IN0[11] is visible the following cycle.
  - If the FIFO is full: no push, ack0 held. Accept on the first edge where count < DEPTH. The core must keep its payload stable until the ack flips.
  - RX_VALID rises the cycle after the push. Write-then-read latency is 1 cycle.
  - Full FIFO with a pop in the same cycle: the pop is performed, the push is blocked that cycle (full is evaluated on the pre-edge count) and accepted next cycle.
  - Empty FIFO with a push in the same cycle: no pop is possible, since RX_VALID=0.
  - Pointers wrap modulo DEPTH. Count is AW+1 bits, range 0..DEPTH.
- Host→core channel:
  - Push on TX_VALID&&TX_READY. Empty and full behave as above.
  - Presenter FSM, IDLE/WAIT:
    - IDLE: if the FIFO is non-empty, latch the head into CORE_IN1[10:0], flip req1 (CORE_IN1[11]) in the same update, go to WAIT. The head is not popped yet.
    - WAIT: CORE_IN1 is held stable. When CORE_OUT1[11]==req1, pop the head and go to IDLE.
  - Minimum spacing is 2 cycles per word plus core response time.
  - A host push into an empty FIFO is presented on CORE_IN1 2 cycles later: push edge, then IDLE load edge.
  - Simultaneous host push and presenter pop with count==DEPTH: the pop happens, the push is blocked (TX_READY was 0).
- Both channels are independent and may operate in the same cycle.
- No combinational path from any input to any output except RX_DATA/RX_VALID from FIFO state (registered) and TX_READY from count (registered).

Optional Feature:
- Macro: PORT_MAILBOX_STATUS_EN.
- Defined: CORE_IN0[10:0] is a registered status word, updated every cycle:
  - [3:0] core→host FIFO count (saturate 15)
  - [7:4] host→core FIFO count (saturate 15)
  - [8] presenter in WAIT
  - [10:9] 0
- Not defined: CORE_IN0[10:0] is constant 0 and no status logic is synthesized.

Test Plan:
- Reset check: hold RES=1 for 12 cycles → CORE_IN0=0x000, CORE_IN1=0x000, RX_VALID=0, TX_READY=0; first cycle after release → TX_READY=1.
- Core→host single word: CORE_OUT0=0x855 (toggle 1, payload 0x055) → next cycle CORE_IN0[11]=1, RX_VALID=1, RX_DATA=0x055; RX_READY=1 → RX_VALID=0.
- Backpressure: 8 core words 0x001..0x008 with RX_READY=0, then a 9th word 0x009 → ack0 does not flip for the 9th; one pop → ack flips the cycle after; host then drains 0x002..0x009 in order.
- Host→core: TX 0x123 then 0x456 back-to-back → CORE_IN1=0x923. Core echoes OUT1[11]=1 → CORE_IN1 becomes 0x456 with [11]=0 (0x456) 2 cycles later; echo OUT1[11]=0 → FSM IDLE, TX FIFO empty.
- Reset mid-transfer: FSM in WAIT with 3 words queued each way, assert RES → all FIFOs empty, CORE_IN1=0, RX_VALID=0, and no stale word appears after release.
- With PORT_MAILBOX_STATUS_EN: 3 core words pending, 2 host words queued with presenter waiting → CORE_IN0[10:0]=0x123; without the macro → 0x000.
